// File: rtl/inta_sequencer_pkg.sv
// Shared types and constants for the PIC interrupt-acknowledge sequencer.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    G1   = 3'd2,
    P2   = 3'd3,
    G2   = 3'd4,
    P3   = 3'd5
  } inta_state_e;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;
  localparam logic [2:0] SPURIOUS_IR = 3'd7;
  localparam logic       MODE_8080   = 1'b0;
  localparam logic       MODE_8086   = 1'b1;

  // ICW fields frozen at the first INTA pulse so mid-cycle reprogramming cannot tear a vector.
  typedef struct packed {
    logic       spen;
    logic       single;
    logic       mode;
    logic       aeoi;
    logic [7:0] sreg;
    logic [4:0] vbase;
    logic [7:0] callHi;
    logic [2:0] callLo;
    logic       adi;
  } icw_cfg_t;

endpackage

// File: rtl/inta_sequencer_vector_mux.sv
// Combinational formatter for the CALL opcode / vector byte presented in each INTA pulse.
module inta_vector_mux
  import pic_pkg::*;
(
  input  inta_state_e state_i,
  input  logic        mode_i,
  input  logic [2:0]  isrIndex_i,
  input  logic [4:0]  vectorBase_i,
  input  logic [7:0]  callAddrHigh_i,
  input  logic [2:0]  callAddrLow_i,
  input  logic        interval4_i,
  output logic [7:0]  vecByte_o,
  output logic        vecValid_o
);

  always_comb begin
    vecByte_o  = 8'h00;
    vecValid_o = 1'b0;
    case (state_i)
      P1: begin
        if (mode_i == MODE_8080) begin
          vecByte_o  = CALL_OPCODE;
          vecValid_o = 1'b1;
        end
      end
      P2: begin
        vecValid_o = 1'b1;
        if (mode_i == MODE_8086) begin
          vecByte_o = {vectorBase_i, isrIndex_i};
        end else if (interval4_i) begin
          vecByte_o = {callAddrLow_i, isrIndex_i, 2'b00};
        end else begin
          vecByte_o = {callAddrLow_i[2:1], isrIndex_i, 3'b000};
        end
      end
      P3: begin
        if (mode_i == MODE_8080) begin
          vecByte_o  = callAddrHigh_i;
          vecValid_o = 1'b1;
        end
      end
      default: begin
        vecByte_o  = 8'h00;
        vecValid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inta_sequencer.sv
// INTA cycle sequencer: owns CAS and data-bus drive for 8080/8086 acknowledge cycles.
// Define INTA_TIMEOUT_EN to add a gap watchdog that aborts a stalled sequence.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int CAS_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 INTA_n,
  input  logic                 intRequest,
  input  logic [CAS_WIDTH-1:0] interruptLocation,
  input  logic                 SPEN,
  input  logic                 singleMode,
  input  logic                 mode8086,
  input  logic                 autoEOI,
  input  logic [7:0]           SReg,
  input  logic [4:0]           vectorBase,
  input  logic [7:0]           callAddrHigh,
  input  logic [2:0]           callAddrLow,
  input  logic                 interval4,
  input  logic [CAS_WIDTH-1:0] CASIn,
  output logic [CAS_WIDTH-1:0] CASOut,
  output logic                 CASOE,
  output logic                 INT,
  output logic [7:0]           dataOut,
  output logic                 dataOE,
  output logic                 setISR,
  output logic                 clearISR,
  output logic [CAS_WIDTH-1:0] isrIndex,
  output logic                 busy
);

  inta_state_e          state_q, state_d;
  icw_cfg_t             cfg_q, cfg_d, cfgIn;
  logic [CAS_WIDTH-1:0] isr_q, isr_d;
  logic                 spur_q, spur_d;
  logic                 slaveSel_q, slaveSel_d;
  logic                 inta_q;
  logic                 int_q, int_d;
  logic                 setIsr_q, setIsr_d;
  logic                 clearIsr_q, clearIsr_d;
  logic                 casOe_q, casOe_d;
  logic [CAS_WIDTH-1:0] casOut_q, casOut_d;
  logic                 dataOe_q, dataOe_d;
  logic [7:0]           dataOut_q, dataOut_d;
  logic                 busy_q, busy_d;
  logic                 fall, rise, cascTarget, chipDrives, vecValid;
  logic [7:0]           vecByte;

`ifdef INTA_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  assign fall = inta_q & ~INTA_n;
  assign rise = ~inta_q & INTA_n;

  always_comb begin
    cfgIn        = '0;
    cfgIn.spen   = SPEN;
    cfgIn.single = singleMode;
    cfgIn.mode   = mode8086;
    cfgIn.aeoi   = autoEOI;
    cfgIn.sreg   = SReg;
    cfgIn.vbase  = vectorBase;
    cfgIn.callHi = callAddrHigh;
    cfgIn.callLo = callAddrLow;
    cfgIn.adi    = interval4;
  end

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    isr_d      = isr_q;
    spur_d     = spur_q;
    slaveSel_d = slaveSel_q;
    int_d      = int_q;
    setIsr_d   = 1'b0;
    clearIsr_d = 1'b0;
    case (state_q)
      IDLE: begin
        int_d = intRequest;
        if (fall) begin
          // A request that has not yet reached INT is treated as spurious.
          state_d    = P1;
          int_d      = 1'b0;
          cfg_d      = cfgIn;
          spur_d     = ~(intRequest & int_q);
          isr_d      = spur_d ? CAS_WIDTH'(SPURIOUS_IR) : interruptLocation;
          setIsr_d   = ~spur_d;
          slaveSel_d = 1'b0;
        end
      end
      P1: if (rise) state_d = G1;
      G1: begin
        if (fall) begin
          state_d    = P2;
          slaveSel_d = ~cfg_q.spen & ~cfg_q.single & (CASIn == cfg_q.sreg[CAS_WIDTH-1:0]);
        end
      end
      P2: begin
        if (rise) begin
          if (cfg_q.mode == MODE_8086) begin
            state_d    = IDLE;
            clearIsr_d = cfg_q.aeoi & ~spur_q;
          end else begin
            state_d = G2;
          end
        end
      end
      G2: if (fall) state_d = P3;
      P3: begin
        if (rise) begin
          state_d    = IDLE;
          clearIsr_d = cfg_q.aeoi & ~spur_q;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef INTA_TIMEOUT_EN
    cnt_d = '0;
    if ((state_q == G1 || state_q == G2) && state_d == state_q) begin
      if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif

    // Outputs are derived from next-state values so they appear one clock after the sampled edge.
    cascTarget = cfg_d.spen & ~cfg_d.single & cfg_d.sreg[isr_d];
    chipDrives = cfg_d.single | (cfg_d.spen & ~cascTarget) | slaveSel_d;
    casOe_d    = (state_d != IDLE) & cascTarget;
    casOut_d   = casOe_d ? isr_d : '0;
    dataOe_d   = vecValid & chipDrives;
    dataOut_d  = dataOe_d ? vecByte : 8'h00;
    busy_d     = (state_d != IDLE);
  end

  inta_vector_mux uVecMux (
    .state_i        (state_d),
    .mode_i         (cfg_d.mode),
    .isrIndex_i     (isr_d[2:0]),
    .vectorBase_i   (cfg_d.vbase),
    .callAddrHigh_i (cfg_d.callHi),
    .callAddrLow_i  (cfg_d.callLo),
    .interval4_i    (cfg_d.adi),
    .vecByte_o      (vecByte),
    .vecValid_o     (vecValid)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      isr_q      <= '0;
      spur_q     <= 1'b0;
      slaveSel_q <= 1'b0;
      inta_q     <= 1'b1;
      int_q      <= 1'b0;
      setIsr_q   <= 1'b0;
      clearIsr_q <= 1'b0;
      casOe_q    <= 1'b0;
      casOut_q   <= '0;
      dataOe_q   <= 1'b0;
      dataOut_q  <= 8'h00;
      busy_q     <= 1'b0;
`ifdef INTA_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      isr_q      <= isr_d;
      spur_q     <= spur_d;
      slaveSel_q <= slaveSel_d;
      inta_q     <= INTA_n;
      int_q      <= int_d;
      setIsr_q   <= setIsr_d;
      clearIsr_q <= clearIsr_d;
      casOe_q    <= casOe_d;
      casOut_q   <= casOut_d;
      dataOe_q   <= dataOe_d;
      dataOut_q  <= dataOut_d;
      busy_q     <= busy_d;
`ifdef INTA_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign CASOut   = casOut_q;
  assign CASOE    = casOe_q;
  assign INT      = int_q;
  assign dataOut  = dataOut_q;
  assign dataOE   = dataOe_q;
  assign setISR   = setIsr_q;
  assign clearISR = clearIsr_q;
  assign isrIndex = isr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: directed vector table, corner sequences, random transactions.
module tb_inta_sequencer;

  typedef struct {
    logic       spen, single, m8086, aeoi, adi, req;
    logic [2:0] ir, casIn;
    logic [7:0] sreg;
    logic [4:0] vbase;
    logic [7:0] hi;
    logic [2:0] lo;
    logic       oe1; logic [7:0] b1;
    logic       oe2; logic [7:0] b2;
    logic       oe3; logic [7:0] b3;
    logic       casOe; logic [2:0] cas;
    logic [2:0] isr;
    logic       set, clr;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST, INTA_n, intRequest, SPEN, singleMode, mode8086, autoEOI, interval4;
  logic [2:0] interruptLocation, callAddrLow, CASIn;
  logic [7:0] SReg, callAddrHigh;
  logic [4:0] vectorBase;
  logic [2:0] CASOut, isrIndex;
  logic       CASOE, INT, dataOE, setISR, clearISR, busy;
  logic [7:0] dataOut;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  inta_sequencer #(.CAS_WIDTH(3), .TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RST(RST), .INTA_n(INTA_n), .intRequest(intRequest),
    .interruptLocation(interruptLocation), .SPEN(SPEN), .singleMode(singleMode),
    .mode8086(mode8086), .autoEOI(autoEOI), .SReg(SReg), .vectorBase(vectorBase),
    .callAddrHigh(callAddrHigh), .callAddrLow(callAddrLow), .interval4(interval4),
    .CASIn(CASIn), .CASOut(CASOut), .CASOE(CASOE), .INT(INT), .dataOut(dataOut),
    .dataOE(dataOE), .setISR(setISR), .clearISR(clearISR), .isrIndex(isrIndex), .busy(busy)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: expected bus activity of a whole acknowledge cycle.
  function automatic vec_t computeExpected(input vec_t v);
    vec_t r = v;
    logic spur, casc, slave, drives;
    spur   = ~v.req;
    r.isr  = spur ? 3'd7 : v.ir;
    casc   = v.spen & ~v.single & v.sreg[r.isr];
    slave  = ~v.spen & ~v.single & (v.casIn == v.sreg[2:0]);
    drives = v.single | (v.spen & ~casc) | slave;
    r.oe1  = ~v.m8086 & (v.single | (v.spen & ~casc));
    r.b1   = r.oe1 ? 8'hCD : 8'h00;
    r.oe2  = drives;
    if (v.m8086)    r.b2 = {v.vbase, r.isr};
    else if (v.adi) r.b2 = {v.lo, r.isr, 2'b00};
    else            r.b2 = {v.lo[2:1], r.isr, 3'b000};
    if (!r.oe2) r.b2 = 8'h00;
    r.oe3   = ~v.m8086 & drives;
    r.b3    = r.oe3 ? v.hi : 8'h00;
    r.casOe = casc;
    r.cas   = casc ? r.isr : 3'd0;
    r.set   = ~spur;
    r.clr   = v.aeoi & ~spur;
    return r;
  endfunction

  task automatic loadConfig(input vec_t v);
    SPEN = v.spen; singleMode = v.single; mode8086 = v.m8086; autoEOI = v.aeoi;
    interval4 = v.adi; intRequest = v.req; interruptLocation = v.ir; CASIn = v.casIn;
    SReg = v.sreg; vectorBase = v.vbase; callAddrHigh = v.hi; callAddrLow = v.lo;
    INTA_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int   pulses;
    logic expOe;
    logic [7:0] expB;
    loadConfig(v);
    tick(); tick();
    checkOutput({tag, " INT idle"}, INT, v.req);
    pulses = v.m8086 ? 2 : 3;
    for (int p = 1; p <= pulses; p++) begin
      expOe = (p == 1) ? v.oe1 : (p == 2) ? v.oe2 : v.oe3;
      expB  = (p == 1) ? v.b1  : (p == 2) ? v.b2  : v.b3;
      INTA_n = 1'b0;
      tick();
      checkOutput($sformatf("%s P%0d dataOE", tag, p), dataOE, expOe);
      checkOutput($sformatf("%s P%0d dataOut", tag, p), dataOut, expB);
      checkOutput($sformatf("%s P%0d CASOE", tag, p), CASOE, v.casOe);
      checkOutput($sformatf("%s P%0d CASOut", tag, p), CASOut, v.cas);
      checkOutput($sformatf("%s P%0d isrIndex", tag, p), isrIndex, v.isr);
      checkOutput($sformatf("%s P%0d busy", tag, p), busy, 1'b1);
      checkOutput($sformatf("%s P%0d INT", tag, p), INT, 1'b0);
      if (p == 1) begin
        checkOutput({tag, " setISR"}, setISR, v.set);
        // Scramble live inputs; the latched copies must carry the rest of the cycle.
        interruptLocation = ~v.ir; vectorBase = ~v.vbase; callAddrHigh = ~v.hi;
        callAddrLow = ~v.lo; SReg = ~v.sreg; interval4 = ~v.adi; intRequest = ~v.req;
      end
      tick();
      checkOutput($sformatf("%s P%0d setISR once", tag, p), setISR, 1'b0);
      checkOutput($sformatf("%s P%0d dataOut hold", tag, p), dataOut, expB);
      INTA_n = 1'b1;
      tick();
      checkOutput($sformatf("%s G%0d dataOE", tag, p), dataOE, 1'b0);
      if (p == pulses) begin
        checkOutput({tag, " clearISR"}, clearISR, v.clr);
        checkOutput({tag, " busy end"}, busy, 1'b0);
        checkOutput({tag, " CASOE end"}, CASOE, 1'b0);
      end else begin
        checkOutput($sformatf("%s G%0d clearISR", tag, p), clearISR, 1'b0);
        checkOutput($sformatf("%s G%0d busy", tag, p), busy, 1'b1);
        checkOutput($sformatf("%s G%0d CASOE", tag, p), CASOE, v.casOe);
      end
    end
    tick();
    checkOutput({tag, " clearISR once"}, clearISR, 1'b0);
  endtask

  vec_t table_q[8];
  vec_t v;

  initial begin
    // spen single m8086 aeoi adi req ir casIn sreg vbase hi lo | oe1 b1 oe2 b2 oe3 b3 casOe cas isr set clr
    table_q[0] = '{1,1,1,0,0,1,3'd3,3'd0,8'h00,5'h09,8'h00,3'd0, 0,8'h00,1,8'h4B,0,8'h00, 0,3'd0,3'd3,1,0};
    table_q[1] = '{1,0,0,0,1,1,3'd6,3'd0,8'h00,5'h00,8'h12,3'd5, 1,8'hCD,1,8'hB8,1,8'h12, 0,3'd0,3'd6,1,0};
    table_q[2] = '{1,0,1,1,0,1,3'd5,3'd0,8'h3A,5'h10,8'h00,3'd0, 0,8'h00,0,8'h00,0,8'h00, 1,3'd5,3'd5,1,1};
    table_q[3] = '{0,0,1,0,0,1,3'd1,3'd2,8'h02,5'h1F,8'h00,3'd0, 0,8'h00,1,8'hF9,0,8'h00, 0,3'd0,3'd1,1,0};
    table_q[4] = '{0,0,1,0,0,1,3'd1,3'd4,8'h02,5'h1F,8'h00,3'd0, 0,8'h00,0,8'h00,0,8'h00, 0,3'd0,3'd1,1,0};
    table_q[5] = '{1,1,1,1,0,0,3'd2,3'd0,8'h00,5'h09,8'h00,3'd0, 0,8'h00,1,8'h4F,0,8'h00, 0,3'd0,3'd7,0,0};
    table_q[6] = '{1,1,0,1,0,1,3'd2,3'd0,8'h00,5'h00,8'hAB,3'd6, 1,8'hCD,1,8'hD0,1,8'hAB, 0,3'd0,3'd2,1,1};
    table_q[7] = '{1,0,0,0,1,1,3'd4,3'd0,8'hFF,5'h00,8'h55,3'd1, 0,8'h00,0,8'h00,0,8'h00, 1,3'd4,3'd4,1,0};

    RST = 1'b1;
    loadConfig(table_q[0]);
    tick(); tick();
    checkOutput("reset outputs", {INT, CASOE, CASOut, dataOE, dataOut, setISR, clearISR, isrIndex, busy}, '0);
    RST = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(table_q[i], $sformatf("vec%0d", i));

    // Reset while parked in the first gap.
    loadConfig(table_q[2]);
    tick(); tick();
    INTA_n = 1'b0; tick();
    INTA_n = 1'b1; tick();
    checkOutput("G1 CASOE before reset", CASOE, 1'b1);
    RST = 1'b1; tick();
    checkOutput("reset in G1", {INT, CASOE, CASOut, dataOE, dataOut, setISR, clearISR, isrIndex, busy}, '0);
    RST = 1'b0; tick(); tick();

    // Stall in the first gap.
    INTA_n = 1'b0; tick();
    INTA_n = 1'b1; tick();
    repeat (7) tick();
    checkOutput("G1 stall busy", busy, 1'b1);
`ifdef INTA_TIMEOUT_EN
    tick();
    checkOutput("timeout busy", busy, 1'b0);
    checkOutput("timeout CASOE", CASOE, 1'b0);
    checkOutput("timeout clearISR", clearISR, 1'b0);
`else
    repeat (13) tick();
    checkOutput("no-timeout busy", busy, 1'b1);
    checkOutput("no-timeout CASOE", CASOE, 1'b1);
    INTA_n = 1'b0; tick();
    INTA_n = 1'b1; tick();
    checkOutput("stall end clearISR", clearISR, 1'b1);
`endif
    tick(); tick();

    // INTA held low: state and one-shot setISR persist.
    loadConfig(table_q[0]);
    tick(); tick();
    INTA_n = 1'b0; tick();
    repeat (10) tick();
    checkOutput("hold low busy", busy, 1'b1);
    checkOutput("hold low setISR", setISR, 1'b0);
    checkOutput("hold low dataOE", dataOE, 1'b0);
    INTA_n = 1'b1; tick();
    INTA_n = 1'b0; tick();
    checkOutput("hold low P2 dataOut", dataOut, 8'h4B);
    INTA_n = 1'b1; tick(); tick();

    // Request arriving on the same clock as the first INTA fall is spurious.
    v = table_q[0];
    v.req = 1'b0; v.aeoi = 1'b1;
    loadConfig(v);
    tick(); tick();
    intRequest = 1'b1; INTA_n = 1'b0; tick();
    checkOutput("late req isrIndex", isrIndex, 3'd7);
    checkOutput("late req setISR", setISR, 1'b0);
    INTA_n = 1'b1; tick();
    INTA_n = 1'b0; tick();
    INTA_n = 1'b1; tick();
    checkOutput("late req clearISR", clearISR, 1'b0);
    tick();

    for (int i = 0; i < 40; i++) begin
      v.spen = 1'($urandom); v.single = 1'($urandom); v.m8086 = 1'($urandom);
      v.aeoi = 1'($urandom); v.adi = 1'($urandom);
      v.req  = ($urandom_range(0, 5) != 0);
      v.ir   = 3'($urandom); v.sreg = 8'($urandom);
      v.casIn = ($urandom_range(0, 1) == 1) ? v.sreg[2:0] : 3'($urandom);
      v.vbase = 5'($urandom); v.hi = 8'($urandom); v.lo = 3'($urandom);
      applyStimulus(computeExpected(v), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
